digi_ota_array: RTL and testbench
=================================

DIGI_OTA_ARRAY -- requirements
Module: digi_ota_array

Interface
REQ-001 The block SHALL have parameter CH, default 4: number of independent OTA channels (1..8).
REQ-002 The block SHALL have parameter FILT, default 2: consecutive identical samples needed to accept a decision (1..15).
REQ-003 The block SHALL have parameter ACC_W, default 6: integrator width in bits (4..8).
REQ-004 The block SHALL have parameter HYST, default 4: integrator hysteresis half-band, which must be less than 2^(ACC_W-1).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port ena, input, 1 bit: block enable, where 0 holds all channels in idle.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 LATCH, 01 TRISTATE, 10 INTEGRATE, 11 reserved (behaves as LATCH).
REQ-009 The block SHALL have port vip, input, CH bits: per-channel non-inverting input, asynchronous.
REQ-010 The block SHALL have port vin, input, CH bits: per-channel inverting input, asynchronous.
REQ-011 The block SHALL have port out, output, CH bits: per-channel output value.
REQ-012 The block SHALL have port out_oe, output, CH bits: per-channel drive enable, where 1 = driven and 0 = high-Z.
REQ-013 The block SHALL have port chg, output, CH bits: one-cycle pulse when that channel's out or out_oe changes.

Function
REQ-014 Each of vip and vin SHALL pass through a 2-flop synchronizer per channel.
REQ-015 Synchronized inputs SHALL be classified per cycle as UP (vip=1, vin=0), DN (vip=0, vin=1) or EQ (equal).
REQ-016 A classification SHALL be accepted only after FILT consecutive identical samples; any differing sample restarts the count at 1; the count saturates at FILT.
REQ-017 The channel FSM SHALL have exactly three states: FLOAT (out=0, oe=0), DRV_LO (out=0, oe=1) and DRV_HI (out=1, oe=1).
REQ-018 In LATCH mode, accepted UP SHALL go to DRV_HI, accepted DN SHALL go to DRV_LO, and EQ SHALL hold the current state, including FLOAT.
REQ-019 In TRISTATE mode, accepted UP SHALL go to DRV_HI, accepted DN SHALL go to DRV_LO, and accepted EQ SHALL go to FLOAT.
REQ-020 In INTEGRATE mode, the unsigned accumulator SHALL add 1 per sample on UP, subtract 1 per sample on DN, and hold on EQ, saturating at 0 and 2^ACC_W-1; the filter SHALL be bypassed.
REQ-021 In INTEGRATE mode, the FSM SHALL go to DRV_HI when acc >= MID+HYST, go to DRV_LO when acc <= MID-HYST, and otherwise hold, where MID = 2^(ACC_W-1); FLOAT SHALL exit on the first threshold crossing.
REQ-022 Latency SHALL be FILT+2 clock edges from a stable input change, present before edge t0, to out/oe updated at edge t0+FILT+2 (LATCH/TRISTATE).
REQ-023 chg SHALL be registered and assert in the same cycle out/oe first shows the new value.
REQ-024 Any change of mode SHALL, on the next edge, force all channels to FLOAT, clear filter counts, and reload acc to MID; chg SHALL pulse for channels that were driven.
REQ-025 ena=0 SHALL apply the REQ-024 idle state every cycle while low; synchronizers keep sampling; normal operation resumes on the first edge with ena=1.
REQ-026 Channels SHALL be fully independent; simultaneous decisions on several channels SHALL all take effect in the same cycle.
REQ-027 out SHALL be 0 whenever out_oe is 0.

Reset
REQ-028 rst_n low SHALL asynchronously set synchronizers to 0, filter counts to 0, acc to MID, FSM to FLOAT, out=0, out_oe=0 and chg=0.
REQ-029 Reset asserted mid-decision SHALL discard partial filter counts; after release, the first decision needs a full FILT+2 edges.
REQ-030 The captured previous-mode register SHALL reset to 00, so that releasing reset with a different mode does not generate a chg pulse.

Structure
REQ-031 Package digi_ota_pkg SHALL hold the mode encoding constants, the FSM state enum and the UP/DN/EQ class enum.
REQ-032 Sub-module digi_ota_chan (synchronizer, filter, accumulator, FSM, chg) SHALL be instantiated CH times by a generate loop; the top SHALL hold only mode-change detection and ena gating.

Verification
REQ-033 Reset, then LATCH with ch0 vip=1, vin=0 held: out[0]=1, oe[0]=1 and chg[0] pulse exactly at edge 4 (FILT=2); other channels FLOAT.
REQ-034 LATCH, ch1 DRV_HI, then vip=vin=1: state held, no chg; in TRISTATE the same stimulus gives oe[1]=0, out[1]=0 after 4 edges.
REQ-035 1-cycle glitch UP on ch2 during steady DN: no output change and no chg.
REQ-036 INTEGRATE, ACC_W=6, HYST=4, constant UP: DRV_HI after acc reaches 36 (4 UP samples past sync); hold UP 40 more cycles: acc saturates at 63; switch to DN: DRV_LO when acc reaches 28.
REQ-037 All channels driven, mode 00->01: next edge all FLOAT with chg=all ones; then ena=0 for 10 cycles with inputs toggling: outputs stay FLOAT.
REQ-038 rst_n pulsed low mid-filter (after 1 of 2 samples): outputs 0 immediately (asynchronous); after release, the decision takes a full 4 edges.

Source files
------------

// File: rtl/digi_ota_pkg.sv
// -----------------------------------------------------------------------------
// digi_ota_pkg
// Shared definitions for the digital OTA channel array: the mode encoding,
// the channel output state machine states and the per-sample input class.
// Also provides the helper that turns a synchronized (vip, vin) pair into
// an input class.
// -----------------------------------------------------------------------------
package digi_ota_pkg;

  // Operating mode encoding; 2'b11 is reserved and decodes as LATCH
  localparam logic [1:0] MODE_LATCH = 2'b00;
  localparam logic [1:0] MODE_TRI   = 2'b01;
  localparam logic [1:0] MODE_INTEG = 2'b10;

  // Channel output states: {out, oe} pairs are all distinct, so any state
  // change is also a visible output change
  typedef enum logic [1:0] {
    ST_FLOAT  = 2'b00,
    ST_DRV_LO = 2'b01,
    ST_DRV_HI = 2'b11
  } chanState_e;

  // Per-sample comparison result
  typedef enum logic [1:0] {
    CLS_EQ = 2'b00,
    CLS_UP = 2'b01,
    CLS_DN = 2'b10
  } inClass_e;

  function automatic inClass_e classify(input logic p, input logic n);
    if (p == n) return CLS_EQ;
    return p ? CLS_UP : CLS_DN;
  endfunction

endpackage

// File: rtl/digi_ota_chan.sv
// -----------------------------------------------------------------------------
// digi_ota_chan
// One OTA channel: 2-flop synchronizers on vip/vin, a run-length filter that
// accepts a class after FILT identical samples, a saturating integrator, the
// three-state output FSM and a registered change pulse.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_i      idle request (mode change or block disabled): float output,
//                drop filter history, recentre the integrator
//   mode_i       operating mode (see digi_ota_pkg)
//   vip_i, vin_i asynchronous comparator inputs
//   out_o, oe_o  output value and drive enable
//   chg_o        one-cycle pulse when out_o/oe_o change
// -----------------------------------------------------------------------------
module digi_ota_chan
  import digi_ota_pkg::*;
#(
  parameter int FILT  = 2,
  parameter int ACC_W = 6,
  parameter int HYST  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic [1:0] mode_i,
  input  logic       vip_i,
  input  logic       vin_i,
  output logic       out_o,
  output logic       oe_o,
  output logic       chg_o
);

  localparam int                 CNT_W    = $clog2(FILT + 1);
  localparam logic [CNT_W-1:0]   FILT_CNT = CNT_W'(FILT);
  localparam logic [ACC_W-1:0]   MID      = ACC_W'(1) << (ACC_W - 1);
  localparam logic [ACC_W-1:0]   ACC_MAX  = '1;
  localparam logic [ACC_W-1:0]   THR_HI   = MID + ACC_W'(HYST);
  localparam logic [ACC_W-1:0]   THR_LO   = MID - ACC_W'(HYST);

  logic [1:0]       vipSync_q, vinSync_q;
  inClass_e         sampleCls;
  inClass_e         runCls_q, runCls_d;
  logic [CNT_W-1:0] runCnt_q, runCnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  chanState_e       state_q, state_d;
  logic             chg_q;
  logic             accepted;

  assign sampleCls = classify(vipSync_q[1], vinSync_q[1]);

  // The decision uses the registered run count, so an accepted class acts one
  // edge after the count saturates; this gives FILT+2 edges of total latency.
  assign accepted = (runCnt_q == FILT_CNT);

  // Next-state logic: filter run tracking, integrator and output FSM.
  // The integrator thresholds look at the registered accumulator value.
  always_comb begin
    runCls_d = runCls_q;
    runCnt_d = runCnt_q;
    acc_d    = acc_q;
    state_d  = state_q;
    if (clear_i) begin
      runCnt_d = '0;
      acc_d    = MID;
      state_d  = ST_FLOAT;
    end else begin
      // A count of zero means no history, so the first sample always starts a run
      if ((runCnt_q != '0) && (sampleCls == runCls_q)) begin
        if (!accepted) runCnt_d = runCnt_q + CNT_W'(1);
      end else begin
        runCls_d = sampleCls;
        runCnt_d = CNT_W'(1);
      end
      case (mode_i)
        MODE_INTEG: begin
          if ((sampleCls == CLS_UP) && (acc_q != ACC_MAX)) acc_d = acc_q + ACC_W'(1);
          else if ((sampleCls == CLS_DN) && (acc_q != '0)) acc_d = acc_q - ACC_W'(1);
          if (acc_q >= THR_HI)      state_d = ST_DRV_HI;
          else if (acc_q <= THR_LO) state_d = ST_DRV_LO;
        end
        MODE_TRI: begin
          if (accepted) begin
            case (runCls_q)
              CLS_UP:  state_d = ST_DRV_HI;
              CLS_DN:  state_d = ST_DRV_LO;
              default: state_d = ST_FLOAT;
            endcase
          end
        end
        default: begin
          if (accepted) begin
            case (runCls_q)
              CLS_UP:  state_d = ST_DRV_HI;
              CLS_DN:  state_d = ST_DRV_LO;
              default: state_d = state_q;
            endcase
          end
        end
      endcase
    end
  end

  // State registers; synchronizers keep sampling even while the channel is
  // held idle so that data is already settled when operation resumes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vipSync_q <= '0;
      vinSync_q <= '0;
      runCls_q  <= CLS_EQ;
      runCnt_q  <= '0;
      acc_q     <= MID;
      state_q   <= ST_FLOAT;
      chg_q     <= 1'b0;
    end else begin
      vipSync_q <= {vipSync_q[0], vip_i};
      vinSync_q <= {vinSync_q[0], vin_i};
      runCls_q  <= runCls_d;
      runCnt_q  <= runCnt_d;
      acc_q     <= acc_d;
      state_q   <= state_d;
      chg_q     <= (state_d != state_q);
    end
  end

  assign out_o = (state_q == ST_DRV_HI);
  assign oe_o  = (state_q != ST_FLOAT);
  assign chg_o = chg_q;

endmodule

// File: rtl/digi_ota_array.sv
// -----------------------------------------------------------------------------
// digi_ota_array
// Array of CH independent digital OTA channels sharing one mode and enable.
// The top only detects mode changes and gates the enable; every channel does
// its own synchronizing, filtering, integrating and output decoding.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           block enable; low holds every channel idle
//   mode          00 LATCH, 01 TRISTATE, 10 INTEGRATE, 11 as LATCH
//   vip, vin      per-channel asynchronous comparator inputs
//   out, out_oe   per-channel output value and drive enable
//   chg           per-channel one-cycle change pulse
// -----------------------------------------------------------------------------
module digi_ota_array #(
  parameter int CH    = 4,
  parameter int FILT  = 2,
  parameter int ACC_W = 6,
  parameter int HYST  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] vip,
  input  logic [CH-1:0] vin,
  output logic [CH-1:0] out,
  output logic [CH-1:0] out_oe,
  output logic [CH-1:0] chg
);

  logic [1:0] prevMode_q;
  logic       idle;

  // Previous mode resets to LATCH; a differing mode at reset release only
  // floats channels that are already floating, so no change pulse results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prevMode_q <= 2'b00;
    else        prevMode_q <= mode;
  end

  assign idle = !ena || (mode != prevMode_q);

  for (genvar g = 0; g < CH; g++) begin : gChan
    digi_ota_chan #(
      .FILT (FILT),
      .ACC_W(ACC_W),
      .HYST (HYST)
    ) uChan (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear_i(idle),
      .mode_i (mode),
      .vip_i  (vip[g]),
      .vin_i  (vin[g]),
      .out_o  (out[g]),
      .oe_o   (out_oe[g]),
      .chg_o  (chg[g])
    );
  end

endmodule

// File: tb/tb_digi_ota_array.sv
// -----------------------------------------------------------------------------
// tb_digi_ota_array
// Directed and randomized stimulus for digi_ota_array, compared every cycle
// against a behavioural model of the channel rules kept in plain integers.
// -----------------------------------------------------------------------------
module tb_digi_ota_array;

  localparam int CH      = 4;
  localparam int FILT    = 2;
  localparam int ACC_W   = 6;
  localparam int HYST    = 4;
  localparam int MID     = 1 << (ACC_W - 1);
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena   = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic [CH-1:0] vip   = '0;
  logic [CH-1:0] vin   = '0;
  logic [CH-1:0] out, out_oe, chg;

  int checks = 0;
  int errors = 0;

  // Behavioural model: two-deep input delay line, the current run of equal
  // samples, the integrator level and the visible output per channel
  int mP1[CH], mN1[CH], mP2[CH], mN2[CH];
  int mRunCls[CH], mRunLen[CH], mAcc[CH];
  int mOut[CH], mOe[CH], mChg[CH];
  int mPrevMode;

  logic [CH-1:0] chgSeen;

  digi_ota_array #(
    .CH(CH), .FILT(FILT), .ACC_W(ACC_W), .HYST(HYST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .mode  (mode),
    .vip   (vip),
    .vin   (vin),
    .out   (out),
    .out_oe(out_oe),
    .chg   (chg)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int ch = 0; ch < CH; ch++) begin
      mP1[ch] = 0; mN1[ch] = 0; mP2[ch] = 0; mN2[ch] = 0;
      mRunCls[ch] = 0; mRunLen[ch] = 0; mAcc[ch] = MID;
      mOut[ch] = 0; mOe[ch] = 0; mChg[ch] = 0;
    end
    mPrevMode = 0;
  endtask

  // One clock edge of the model, using the inputs as driven before the edge.
  // Classes: 0 = equal, 1 = up, 2 = down.
  task automatic modelEdge();
    bit idle;
    idle = !ena || (int'(mode) != mPrevMode);
    for (int ch = 0; ch < CH; ch++) begin
      int cls, oldOut, oldOe, oldAcc, oldRunCls;
      bit settled;
      cls       = (mP2[ch] == mN2[ch]) ? 0 : ((mP2[ch] == 1) ? 1 : 2);
      oldOut    = mOut[ch];
      oldOe     = mOe[ch];
      oldAcc    = mAcc[ch];
      oldRunCls = mRunCls[ch];
      settled   = (mRunLen[ch] == FILT);
      if (idle) begin
        mOut[ch] = 0; mOe[ch] = 0; mRunLen[ch] = 0; mAcc[ch] = MID;
      end else begin
        if (mRunLen[ch] > 0 && cls == mRunCls[ch]) begin
          if (mRunLen[ch] < FILT) mRunLen[ch] = mRunLen[ch] + 1;
        end else begin
          mRunLen[ch] = 1;
          mRunCls[ch] = cls;
        end
        if (mode == 2'b10) begin
          if (cls == 1 && oldAcc < ACC_MAX) mAcc[ch] = oldAcc + 1;
          else if (cls == 2 && oldAcc > 0)  mAcc[ch] = oldAcc - 1;
          if (oldAcc >= MID + HYST) begin
            mOut[ch] = 1; mOe[ch] = 1;
          end else if (oldAcc <= MID - HYST) begin
            mOut[ch] = 0; mOe[ch] = 1;
          end
        end else if (settled) begin
          if (oldRunCls == 1) begin
            mOut[ch] = 1; mOe[ch] = 1;
          end else if (oldRunCls == 2) begin
            mOut[ch] = 0; mOe[ch] = 1;
          end else if (mode == 2'b01) begin
            mOut[ch] = 0; mOe[ch] = 0;
          end
        end
      end
      mChg[ch] = (mOut[ch] != oldOut || mOe[ch] != oldOe) ? 1 : 0;
      mP2[ch] = mP1[ch];
      mN2[ch] = mN1[ch];
      mP1[ch] = int'(vip[ch]);
      mN1[ch] = int'(vin[ch]);
    end
    mPrevMode = int'(mode);
  endtask

  task automatic expectBits(input string tag, input logic [CH-1:0] obs,
                            input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [CH-1:0] eOut, eOe, eChg;
    for (int ch = 0; ch < CH; ch++) begin
      eOut[ch] = (mOut[ch] != 0);
      eOe[ch]  = (mOe[ch] != 0);
      eChg[ch] = (mChg[ch] != 0);
    end
    expectBits({tag, " out"}, out, eOut);
    expectBits({tag, " out_oe"}, out_oe, eOe);
    expectBits({tag, " chg"}, chg, eChg);
    expectBits({tag, " out_gated"}, out & ~out_oe, '0);
  endtask

  // Drive one cycle of inputs, advance model and DUT one edge, then compare
  task automatic applyStimulus(input logic e, input logic [1:0] m,
                               input logic [CH-1:0] p, input logic [CH-1:0] n,
                               input string tag);
    ena  = e;
    mode = m;
    vip  = p;
    vin  = n;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput(tag);
    chgSeen = chgSeen | chg;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    modelReset();
    #2;
    checkOutput(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    chgSeen = '0;
    #1;
    doReset("reset");

    // LATCH, ch0 up: first sampling edge is t0, output flips at t0+4
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 2'b00, 4'b0001, 4'b0000, "latch_up");
      expectBits("latch_up_latency_oe", out_oe, (i == 5) ? 4'b0001 : 4'b0000);
      expectBits("latch_up_latency_chg", chg, (i == 5) ? 4'b0001 : 4'b0000);
    end

    // LATCH, ch1 driven high, then equal inputs hold it with no change pulse
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b00, 4'b0011, 4'b0000, "latch_hi");
    expectBits("ch1_hi", out & 4'b0010, 4'b0010);
    chgSeen = '0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b00, 4'b0011, 4'b0010, "latch_eq");
    expectBits("latch_eq_nochg", chgSeen & 4'b0010, 4'b0000);
    expectBits("latch_eq_hold", out & 4'b0010, 4'b0010);

    // TRISTATE: same equal stimulus floats ch1 four edges after t0
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b01, 4'b0011, 4'b0000, "tri_up");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 2'b01, 4'b0011, 4'b0010, "tri_eq");
      expectBits("tri_eq_float", out_oe & 4'b0010, (i == 5) ? 4'b0000 : 4'b0010);
    end

    // LATCH, ch2 steady down with a one-cycle up glitch
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b00, 4'b0000, 4'b0100, "latch_dn");
    chgSeen = '0;
    applyStimulus(1'b1, 2'b00, 4'b0100, 4'b0000, "glitch");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'b00, 4'b0000, 4'b0100, "post_glitch");
    expectBits("glitch_nochg", chgSeen & 4'b0100, 4'b0000);
    expectBits("glitch_drv_lo", (out_oe & ~out) & 4'b0100, 4'b0100);

    // INTEGRATE, ch3 up: acc 32 -> 36 after four samples, high one edge later
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 4'b1000, 4'b0000, "integ_pre");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 2'b10, 4'b1000, 4'b0000, "integ_up");
      expectBits("integ_hi_time", out & 4'b1000, (i >= 6) ? 4'b1000 : 4'b0000);
    end
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 2'b10, 4'b1000, 4'b0000, "integ_sat");
    // From saturation at 63, 35 down samples reach 28 (two sync edges first)
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 2'b10, 4'b0000, 4'b1000, "integ_dn");
      expectBits("integ_lo_time", out & 4'b1000, (i >= 38) ? 4'b0000 : 4'b1000);
      expectBits("integ_lo_oe", out_oe & 4'b1000, 4'b1000);
    end

    // All channels driven, then a mode change floats every channel at once
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b00, 4'b1111, 4'b0000, "all_hi");
    expectBits("all_hi_oe", out_oe, 4'b1111);
    applyStimulus(1'b1, 2'b01, 4'b1111, 4'b0000, "mode_chg");
    expectBits("mode_chg_float", out_oe, 4'b0000);
    expectBits("mode_chg_pulse", chg, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b01, 4'($urandom), 4'($urandom), "ena_low");
      expectBits("ena_low_float", out_oe, 4'b0000);
    end

    // Reset in the middle of a ch0 decision; ch1 already driven
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 2'b00, 4'b0010, 4'b0000, "pre_rst");
    expectBits("pre_rst_ch1", out_oe, 4'b0010);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 4'b0011, 4'b0000, "mid_filter");
    #1;
    doReset("async_reset");
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 2'b00, 4'b0011, 4'b0000, "post_rst");
      expectBits("post_rst_latency", out_oe, (i >= 5) ? 4'b0011 : 4'b0000);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      logic [1:0]    m;
      logic          e;
      logic [CH-1:0] p, n;
      m = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(0, 3)) : mode;
      e = ($urandom_range(0, 19) != 0);
      p = vip;
      n = vin;
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 5) == 0) begin
          p[ch] = 1'($urandom);
          n[ch] = 1'($urandom);
        end
      end
      applyStimulus(e, m, p, n, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
